// File: rtl/vedacao_multicanal.sv
// Multi-head sealing controller: per-head Moore FSMs sharing one cork stock.
// Optional LIBERA watchdog enabled by defining VEDACAO_WATCHDOG_EN.
module vedacao_multicanal #(
    parameter int CHANNELS    = 4,
    parameter int STOCK_W     = 8,
    parameter int ESTOQUE_INI = 0,
    parameter int SEAL_CYCLES = 3,
    parameter int LOW_STOCK   = 10,
    parameter int LIBERA_MAX  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] garrafa,
    input  logic [CHANNELS-1:0] pos,
    input  logic [CHANNELS-1:0] ack_alarme,
    input  logic                recarga,
    input  logic [STOCK_W-1:0]  recarga_qtd,
    output logic [CHANNELS-1:0] ve,
    output logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] alarme,
    output logic [STOCK_W-1:0]  estoque,
    output logic                estoque_baixo
);

    localparam int CNT_W = (SEAL_CYCLES > 1) ? $clog2(SEAL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SEAL_CYCLES - 1);

    if (CHANNELS < 1 || SEAL_CYCLES < 1 || LIBERA_MAX < 1) begin : g_param_invalid
        $error("vedacao_multicanal: CHANNELS, SEAL_CYCLES and LIBERA_MAX must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEAL   = 3'd1,
        DONE   = 3'd2,
        LIBERA = 3'd3,
        ALARM  = 3'd4
    } estado_t;

    estado_t            estado    [CHANNELS];
    estado_t            estado_nx [CHANNELS];
    logic [CNT_W-1:0]   cnt       [CHANNELS];
    logic [CNT_W-1:0]   cnt_nx    [CHANNELS];

    logic [CHANNELS-1:0] pedido;
    logic [CHANNELS-1:0] concede;
    logic [STOCK_W-1:0]  n_conc;
    logic [STOCK_W-1:0]  estoque_dif;
    logic [STOCK_W:0]    soma;
    logic [STOCK_W-1:0]  estoque_nx;
    logic                estoque_baixo_nx;

`ifdef VEDACAO_WATCHDOG_EN
    localparam int WD_W = $clog2(LIBERA_MAX + 1);
    localparam logic [WD_W-1:0] WD_LIMITE = WD_W'(LIBERA_MAX - 1);

    logic [WD_W-1:0] wd    [CHANNELS];
    logic [WD_W-1:0] wd_nx [CHANNELS];
`endif

    always_comb begin
        pedido = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pedido[i] = (estado[i] == IDLE) && garrafa[i] && pos[i];
        end
    end

    // Fixed priority, lowest index first, never granting more corks than are in stock
    always_comb begin
        concede = '0;
        n_conc  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pedido[i] && (n_conc < estoque)) begin
                concede[i] = 1'b1;
                n_conc     = n_conc + STOCK_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            estado_nx[i] = estado[i];
            cnt_nx[i]    = cnt[i];
            case (estado[i])
                IDLE: begin
                    if (concede[i]) begin
                        estado_nx[i] = SEAL;
                        cnt_nx[i]    = CNT_LOAD;
                    end else if (pedido[i] && (estoque == '0)) begin
                        estado_nx[i] = ALARM;
                    end
                end
                SEAL: begin
                    if (!garrafa[i] || !pos[i]) begin
                        estado_nx[i] = ALARM;
                    end else if (cnt[i] == '0) begin
                        estado_nx[i] = DONE;
                    end else begin
                        cnt_nx[i] = cnt[i] - CNT_W'(1);
                    end
                end
                DONE: estado_nx[i] = LIBERA;
                LIBERA: begin
                    if (!garrafa[i]) begin
                        estado_nx[i] = IDLE;
                    end
`ifdef VEDACAO_WATCHDOG_EN
                    else if (wd[i] == WD_LIMITE) begin
                        estado_nx[i] = ALARM;
                    end
`endif
                end
                ALARM: begin
                    if (ack_alarme[i] && !garrafa[i]) begin
                        estado_nx[i] = IDLE;
                    end
                end
                default: estado_nx[i] = IDLE;
            endcase
        end
    end

`ifdef VEDACAO_WATCHDOG_EN
    // Counter sits at zero outside LIBERA, so it is already clear on entry
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wd_nx[i] = '0;
            if (estado[i] == LIBERA) begin
                wd_nx[i] = wd[i] + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            wd[i] <= wd_nx[i];
        end
    end
`endif

    always_comb begin
        estoque_dif      = estoque - n_conc;
        soma             = {1'b0, estoque_dif} + ({1'b0, recarga_qtd} & {(STOCK_W+1){recarga}});
        estoque_nx       = soma[STOCK_W] ? '1 : soma[STOCK_W-1:0];
        estoque_baixo_nx = (32'(estoque_nx) < LOW_STOCK);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                estado[i] <= IDLE;
            end
            estoque       <= STOCK_W'(ESTOQUE_INI);
            estoque_baixo <= (ESTOQUE_INI < LOW_STOCK);
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                estado[i] <= estado_nx[i];
            end
            estoque       <= estoque_nx;
            estoque_baixo <= estoque_baixo_nx;
        end
    end

    // Seal counters are only meaningful in SEAL and are always loaded on entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt[i] <= cnt_nx[i];
        end
    end

    always_comb begin
        ve     = '0;
        done   = '0;
        alarme = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ve[i]     = (estado[i] == SEAL);
            done[i]   = (estado[i] == DONE);
            alarme[i] = (estado[i] == ALARM);
        end
    end

endmodule

// File: tb/tb_vedacao_multicanal.sv
// Scoreboard bench for vedacao_multicanal: a behavioural model pushes expected
// outputs per cycle, which are popped and compared after each clock edge.
module tb_vedacao_multicanal;

    localparam int CH   = 4;
    localparam int SW   = 8;
    localparam int INI  = 5;
    localparam int SC   = 3;
    localparam int LOW  = 10;
    localparam int LMAX = 16;

    localparam int S_IDLE   = 0;
    localparam int S_SEAL   = 1;
    localparam int S_DONE   = 2;
    localparam int S_LIBERA = 3;
    localparam int S_ALARM  = 4;

    logic          clk;
    logic          reset;
    logic [CH-1:0] garrafa, pos, ack_alarme;
    logic          recarga;
    logic [SW-1:0] recarga_qtd;
    logic [CH-1:0] ve, done, alarme;
    logic [SW-1:0] estoque;
    logic          estoque_baixo;

    typedef struct packed {
        logic [CH-1:0] ve;
        logic [CH-1:0] done;
        logic [CH-1:0] alarme;
        logic [SW-1:0] estoque;
        logic          baixo;
    } esp_t;

    esp_t fila[$];
    int   m_st  [CH];
    int   m_cnt [CH];
    int   m_est;
    int   n_total = 0;
    int   n_ok    = 0;

    vedacao_multicanal #(
        .CHANNELS(CH), .STOCK_W(SW), .ESTOQUE_INI(INI),
        .SEAL_CYCLES(SC), .LOW_STOCK(LOW), .LIBERA_MAX(LMAX)
    ) dut (
        .clk(clk), .reset(reset), .garrafa(garrafa), .pos(pos),
        .ack_alarme(ack_alarme), .recarga(recarga), .recarga_qtd(recarga_qtd),
        .ve(ve), .done(done), .alarme(alarme), .estoque(estoque),
        .estoque_baixo(estoque_baixo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    endtask

    task automatic modelo();
        esp_t e;
        int livre, usados, soma;
        if (!reset) begin
            for (int i = 0; i < CH; i++) m_st[i] = S_IDLE;
            m_est = INI;
        end else begin
            livre  = m_est;
            usados = 0;
            for (int i = 0; i < CH; i++) begin
                case (m_st[i])
                    S_IDLE: if (garrafa[i] && pos[i]) begin
                        if (livre > 0) begin
                            m_st[i] = S_SEAL; m_cnt[i] = SC - 1;
                            livre--; usados++;
                        end else if (m_est == 0) begin
                            m_st[i] = S_ALARM;
                        end
                    end
                    S_SEAL: begin
                        if (!garrafa[i] || !pos[i]) m_st[i] = S_ALARM;
                        else if (m_cnt[i] == 0)     m_st[i] = S_DONE;
                        else                        m_cnt[i]--;
                    end
                    S_DONE:   m_st[i] = S_LIBERA;
                    S_LIBERA: if (!garrafa[i]) m_st[i] = S_IDLE;
                    default:  if (ack_alarme[i] && !garrafa[i]) m_st[i] = S_IDLE;
                endcase
            end
            soma  = m_est - usados + (recarga ? int'(recarga_qtd) : 0);
            m_est = (soma > 255) ? 255 : soma;
        end
        e = '0;
        for (int i = 0; i < CH; i++) begin
            e.ve[i]     = (m_st[i] == S_SEAL);
            e.done[i]   = (m_st[i] == S_DONE);
            e.alarme[i] = (m_st[i] == S_ALARM);
        end
        e.estoque = m_est[SW-1:0];
        e.baixo   = (m_est < LOW);
        fila.push_back(e);
    endtask

    task automatic passo();
        esp_t e;
        modelo();
        @(posedge clk);
        @(negedge clk);
        e = fila.pop_front();
        verifica("ve",            32'(ve),            32'(e.ve));
        verifica("done",          32'(done),          32'(e.done));
        verifica("alarme",        32'(alarme),        32'(e.alarme));
        verifica("estoque",       32'(estoque),       32'(e.estoque));
        verifica("estoque_baixo", 32'(estoque_baixo), 32'(e.baixo));
    endtask

    initial begin
        reset = 1'b0; garrafa = '0; pos = '0; ack_alarme = '0;
        recarga = 1'b0; recarga_qtd = '0;
        for (int i = 0; i < CH; i++) begin m_st[i] = S_IDLE; m_cnt[i] = 0; end
        m_est = INI;

        // reset state
        passo(); passo();
        verifica("rst_estoque", 32'(estoque), 5);
        verifica("rst_baixo",   32'(estoque_baixo), 1);
        reset = 1'b1;

        // single seal on head 0
        garrafa = 4'b0001; pos = 4'b0001;
        passo();
        verifica("single_ve", 32'(ve), 32'(4'b0001));
        verifica("single_estoque", 32'(estoque), 4);
        passo(); passo();
        verifica("single_ve3", 32'(ve[0]), 1);
        passo();
        verifica("single_done", 32'(done), 32'(4'b0001));
        passo(); passo();
        verifica("single_done_once", 32'(done[0]), 0);
        garrafa = '0; pos = '0;
        passo();

        // two heads sealing together leaves stock at 2
        garrafa = 4'b0011; pos = 4'b0011;
        repeat (5) passo();
        garrafa = '0; pos = '0;
        passo();
        verifica("pre_contention", 32'(estoque), 2);

        // contention: three requests, two corks
        garrafa = 4'b0111; pos = 4'b0111;
        passo();
        verifica("cont_ve", 32'(ve), 32'(4'b0011));
        verifica("cont_estoque", 32'(estoque), 0);
        passo();
        verifica("cont_alarme2", 32'(alarme[2]), 1);
        recarga = 1'b1; recarga_qtd = 8'd3;
        passo();
        recarga = 1'b0;
        verifica("refill_keeps_alarm", 32'(alarme[2]), 1);
        passo(); passo(); passo();
        garrafa = '0; pos = '0; ack_alarme = 4'b0100;
        passo();
        verifica("ack_clears", 32'(alarme[2]), 0);
        ack_alarme = '0;

        // bottle lost on head 1 during its second SEAL cycle
        garrafa = 4'b0010; pos = 4'b0010;
        passo(); passo();
        pos = '0;
        passo();
        verifica("lost_alarme", 32'(alarme[1]), 1);
        verifica("lost_ve", 32'(ve[1]), 0);
        verifica("lost_no_refund", 32'(estoque), 2);
        garrafa = '0; ack_alarme = 4'b0010;
        passo();
        ack_alarme = '0;

        // refill to 250, then grant and refill together saturate
        recarga = 1'b1; recarga_qtd = 8'd248;
        passo();
        verifica("refill_250", 32'(estoque), 250);
        garrafa = 4'b0001; pos = 4'b0001; recarga_qtd = 8'd20;
        passo();
        recarga = 1'b0;
        verifica("sat_estoque", 32'(estoque), 255);
        verifica("sat_baixo", 32'(estoque_baixo), 0);

        // reset while head 0 is sealing
        passo();
        reset = 1'b0;
        passo();
        verifica("rst_seal_ve", 32'(ve), 0);
        verifica("rst_seal_estoque", 32'(estoque), 5);
        reset = 1'b1; garrafa = '0; pos = '0;
        passo();

        // bottle held after done: LIBERA waits
        garrafa = 4'b1000; pos = 4'b1000;
        repeat (4) passo();
        pos = '0;
        repeat (LMAX + 8) passo();
        verifica("libera_hold", 32'(alarme[3]), 0);
        garrafa = '0;
        passo();

        // random traffic against the model
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(7) == 0) garrafa[i] = ~garrafa[i];
                pos[i] = garrafa[i] && ($urandom_range(15) != 0);
            end
            ack_alarme  = CH'($urandom_range(15));
            recarga     = ($urandom_range(9) == 0);
            recarga_qtd = SW'($urandom_range(15));
            reset       = ($urandom_range(99) != 0);
            passo();
        end

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
